// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory port arbiter.
package mem_arb_pkg;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} arb_state_t;
  typedef enum logic {OWN_FETCH = 1'b0, OWN_DATA = 1'b1} arb_owner_t;

endpackage

// File: rtl/mem_port_arbiter_chk.sv
// Protocol checks on the requester handshakes and the grant outputs of mem_port_arbiter.
module mem_port_arbiter_chk #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic                clk,
  input logic                reset,
  input logic                i_req,
  input logic [ADDR_W-1:0]   i_addr,
  input logic                i_gnt,
  input logic                d_req,
  input logic                d_we,
  input logic [ADDR_W-1:0]   d_addr,
  input logic [DATA_W-1:0]   d_wdata,
  input logic [DATA_W/8-1:0] d_wstrb,
  input logic                d_gnt
);

  a_i_hold: assert property (@(posedge clk) disable iff (!reset)
    (i_req && !i_gnt) |=> (i_req && $stable(i_addr)));

  a_d_hold: assert property (@(posedge clk) disable iff (!reset)
    (d_req && !d_gnt) |=> (d_req && $stable({d_we, d_addr, d_wdata, d_wstrb})));

  a_one_gnt: assert property (@(posedge clk) disable iff (!reset)
    !(i_gnt && d_gnt));

endmodule

// File: rtl/mem_port_arbiter_pick.sv
// Combinational winner select: data beats fetch unless fetch has reached its starvation limit.
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic       can_issue,
  input  logic       i_req,
  input  logic       d_req,
  input  logic       starved,
  output logic       issue,
  output arb_owner_t winner
);

  // Pick the single port that may issue this cycle
  always_comb begin
    issue  = 1'b0;
    winner = OWN_FETCH;
    if (!can_issue) begin
      issue  = 1'b0;
    end else if (i_req && (starved || !d_req)) begin
      issue  = 1'b1;
      winner = OWN_FETCH;
    end else if (d_req) begin
      issue  = 1'b1;
      winner = OWN_DATA;
    end else begin
      issue  = 1'b0;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between the fetch and load/store ports,
// one transaction in flight, data-over-fetch priority with a fetch starvation guard.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int LAT_W  = $clog2(MEM_LAT + 1);
  localparam int STV_W  = $clog2(STARVE_MAX + 1);
  localparam int STRB_W = DATA_W / 8;
  localparam logic [LAT_W-1:0] LAT_DONE = LAT_W'(MEM_LAT);
  localparam logic [STV_W-1:0] STV_LIM  = STV_W'(STARVE_MAX);

  arb_state_t       state_r, state_nxt_s;
  logic [LAT_W-1:0] lat_cnt_r, lat_cnt_nxt_s;
  arb_owner_t       owner_r, owner_nxt_s;
  logic             owner_we_r, owner_we_nxt_s;
  logic [STV_W-1:0] starve_cnt_r, starve_cnt_nxt_s;
  logic             done_s, can_issue_s, issue_s;
  arb_owner_t       winner_s;

  assign done_s = (state_r == BUSY) && (lat_cnt_r == LAT_DONE);
  // Gating with reset keeps every grant and mem_* output low while reset is held
  assign can_issue_s = reset && ((state_r == IDLE) || done_s);

  arb_pick u_pick (
    .can_issue (can_issue_s),
    .i_req     (i_req),
    .d_req     (d_req),
    .starved   (starve_cnt_r == STV_LIM),
    .issue     (issue_s),
    .winner    (winner_s)
  );

  // Drive grants and the RAM command from the winning port
  always_comb begin
    i_gnt     = 1'b0;
    d_gnt     = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = {ADDR_W{1'b0}};
    mem_wdata = {DATA_W{1'b0}};
    mem_wstrb = {STRB_W{1'b0}};
    if (issue_s && (winner_s == OWN_DATA)) begin
      d_gnt     = 1'b1;
      mem_en    = 1'b1;
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      mem_wstrb = d_we ? d_wstrb : {STRB_W{1'b0}};
    end else if (issue_s) begin
      i_gnt     = 1'b1;
      mem_en    = 1'b1;
      mem_addr  = i_addr;
    end else begin
      mem_en    = 1'b0;
    end
  end

  // Return read data to the owner of the completing access
  always_comb begin
    i_rvalid = 1'b0;
    i_rdata  = {DATA_W{1'b0}};
    d_rvalid = 1'b0;
    d_rdata  = {DATA_W{1'b0}};
    if (done_s && (owner_r == OWN_FETCH)) begin
      i_rvalid = 1'b1;
      i_rdata  = mem_rdata;
    end else if (done_s) begin
      d_rvalid = 1'b1;
      d_rdata  = owner_we_r ? {DATA_W{1'b0}} : mem_rdata;
    end else begin
      i_rvalid = 1'b0;
    end
  end

  // Next-state, latency and starvation bookkeeping
  always_comb begin
    state_nxt_s      = state_r;
    lat_cnt_nxt_s    = lat_cnt_r;
    owner_nxt_s      = owner_r;
    owner_we_nxt_s   = owner_we_r;
    starve_cnt_nxt_s = starve_cnt_r;
    if (issue_s) begin
      state_nxt_s    = BUSY;
      lat_cnt_nxt_s  = LAT_W'(1);
      owner_nxt_s    = winner_s;
      owner_we_nxt_s = (winner_s == OWN_DATA) && d_we;
    end else if (done_s) begin
      state_nxt_s    = IDLE;
      lat_cnt_nxt_s  = {LAT_W{1'b0}};
    end else if (state_r == BUSY) begin
      lat_cnt_nxt_s  = lat_cnt_r + LAT_W'(1);
    end else begin
      state_nxt_s    = IDLE;
    end
    // Only an issue slot where fetch waited and lost advances the count
    if (can_issue_s && i_req && issue_s && (winner_s == OWN_DATA)) begin
      starve_cnt_nxt_s = (starve_cnt_r == STV_LIM) ? STV_LIM : starve_cnt_r + STV_W'(1);
    end else if (can_issue_s) begin
      starve_cnt_nxt_s = {STV_W{1'b0}};
    end else begin
      starve_cnt_nxt_s = starve_cnt_r;
    end
  end

  // State registers; an async reset mid-access drops the transaction
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      lat_cnt_r    <= {LAT_W{1'b0}};
      owner_r      <= OWN_FETCH;
      owner_we_r   <= 1'b0;
      starve_cnt_r <= {STV_W{1'b0}};
    end else begin
      state_r      <= state_nxt_s;
      lat_cnt_r    <= lat_cnt_nxt_s;
      owner_r      <= owner_nxt_s;
      owner_we_r   <= owner_we_nxt_s;
      starve_cnt_r <= starve_cnt_nxt_s;
    end
  end

  mem_port_arbiter_chk #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_chk (
    .clk     (clk),
    .reset   (reset),
    .i_req   (i_req),
    .i_addr  (i_addr),
    .i_gnt   (i_gnt),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_wstrb (d_wstrb),
    .d_gnt   (d_gnt)
  );

endmodule
